// File: rtl/stg2id.sv
// Decode stage of the diad core: splits fetched words into execute-stage fields
// and folds an optional immediate-prefix word into a 24-bit immediate.
module stg2id #(
    parameter logic [7:0] PREFIX_OPC = 8'hFF
) (
    input  logic        iw_clk,
    input  logic        iw_rst_n,
    input  logic        iw_flush,
    input  logic        iw_valid,
    output logic        ow_ready,
    input  logic [23:0] iw_pc,
    input  logic [23:0] iw_instr,
    output logic        ow_valid,
    input  logic        iw_ready,
    output logic [23:0] ow_pc,
    output logic [23:0] ow_instr,
    output logic [7:0]  ow_opc,
    output logic        ow_sgn_en,
    output logic        ow_imm_en,
    output logic [11:0] ow_imm_val,
    output logic [23:0] ow_immsr_val,
    output logic [3:0]  ow_cc,
    output logic [3:0]  ow_tgt_gp,
    output logic [1:0]  ow_tgt_sr,
    output logic [3:0]  ow_src_gp,
    output logic [1:0]  ow_src_sr
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_PREFIXED = 1'b1;

    logic [0:0]  r_state;
    logic [11:0] r_upper;
    logic        r_valid;
    logic [23:0] r_pc;
    logic [23:0] r_instr;
    logic [23:0] r_immsr;

    logic        w_ready;
    logic        w_acc;
    logic        w_is_prefix;
    logic [7:0]  w_opc;
    logic [11:0] w_imm;
    logic [23:0] w_immsr;

    assign w_ready     = ~r_valid | iw_ready;
    assign w_acc       = iw_valid & w_ready;
    assign w_opc       = iw_instr[23:16];
    assign w_imm       = iw_instr[11:0];
    assign w_is_prefix = (w_opc == PREFIX_OPC);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_immsr = {12'b0, w_imm};
        if (r_state == S_PREFIXED) begin
            w_immsr = {r_upper, w_imm};
        end else if (w_opc[6]) begin
            w_immsr = {{12{w_imm[11]}}, w_imm};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state <= S_IDLE;
            r_upper <= '0;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_immsr <= '0;
        end else if (iw_flush) begin
            r_state <= S_IDLE;
            r_upper <= '0;
            r_valid <= 1'b0;
        end else if (w_acc && w_is_prefix) begin
            // An accept implies the slot is empty or being consumed, so it empties.
            r_state <= S_PREFIXED;
            r_upper <= w_imm;
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_state <= S_IDLE;
            r_valid <= 1'b1;
            r_pc    <= iw_pc;
            r_instr <= iw_instr;
            r_immsr <= w_immsr;
        end else if (iw_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Field outputs are slices of the held word; they stay stable until the next load.
    assign ow_ready     = w_ready;
    assign ow_valid     = r_valid;
    assign ow_pc        = r_pc;
    assign ow_instr     = r_instr;
    assign ow_opc       = r_instr[23:16];
    assign ow_sgn_en    = r_instr[22];
    assign ow_imm_en    = r_instr[23];
    assign ow_imm_val   = r_instr[11:0];
    assign ow_immsr_val = r_immsr;
    assign ow_cc        = r_instr[15:12];
    assign ow_tgt_gp    = r_instr[15:12];
    assign ow_tgt_sr    = r_instr[15:14];
    assign ow_src_gp    = r_instr[11:8];
    assign ow_src_sr    = r_instr[13:12];

endmodule
